// File: rtl/bank_cmd_scheduler_if.sv
// Request/issue bundle between the per-bank queues, the scheduler and the
// command/address encoder. Per-bank fields are packed bank-major (bank 0 in
// the least significant slice).
interface bank_cmd_scheduler_if #(
    parameter int NUM_BANKS = 8,
    parameter int BA_BITS   = 3
);
    logic [NUM_BANKS-1:0]   req_valid;
    logic [2*NUM_BANKS-1:0] req_cmd;
    logic [NUM_BANKS-1:0]   bank_open;
    logic [5*NUM_BANKS-1:0] tP_ba_counter;
    logic [6*NUM_BANKS-1:0] tRAS_counter;
    logic [3*NUM_BANKS-1:0] recode;
    logic                   ref_req;
    logic [NUM_BANKS-1:0]   grant;
    logic                   issue_valid;
    logic [2:0]             issue_cmd;
    logic [BA_BITS-1:0]     issue_bank;
    logic                   ref_pending;
    logic                   ref_ack;

    // Bank-queue / timer side
    modport master (
        output req_valid, req_cmd, bank_open, tP_ba_counter, tRAS_counter, recode, ref_req,
        input  grant, issue_valid, issue_cmd, issue_bank, ref_pending, ref_ack
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_cmd, bank_open, tP_ba_counter, tRAS_counter, recode, ref_req,
        output grant, issue_valid, issue_cmd, issue_bank, ref_pending, ref_ack
    );
endinterface

// File: rtl/bank_cmd_scheduler.sv
// Per-cycle DRAM command scheduler: picks at most one bank command per cycle
// (row hits first, then ACT/PRE, round-robin in each class), enforces tRRD,
// tFAW and tCCD locally, and sequences refresh by draining open banks.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_NORMAL    | all command classes may be granted
// ST_REF_DRAIN | refresh requested; only PRE is granted until banks close
// ST_REF_ISSUE | REF on the bus this cycle, ref_ack pulses
// ST_REF_WAIT  | tRFC recovery, nothing is issued
module bank_cmd_scheduler #(
    parameter int NUM_BANKS = 8,
    parameter int BA_BITS   = 3,
    parameter int TRRD      = 4,
    parameter int TFAW      = 20,
    parameter int TCCD      = 4,
    parameter int TRFC      = 44
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bank_cmd_scheduler_if.slave  sif
);
    localparam int RRD_W = $clog2(TRRD + 1);
    localparam int FAW_W = $clog2(TFAW + 1);
    localparam int CCD_W = $clog2(TCCD + 1);
    localparam int RFC_W = $clog2(TRFC + 1);

    localparam logic [1:0] RC_ACT = 2'b00;
    localparam logic [1:0] RC_RD  = 2'b01;
    localparam logic [1:0] RC_WR  = 2'b10;
    localparam logic [1:0] RC_PRE = 2'b11;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_REF_DRAIN = 2'd1,
        ST_REF_ISSUE = 2'd2,
        ST_REF_WAIT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BA_BITS-1:0]   r_rr;
    logic [RRD_W-1:0]     r_trrd;
    logic [CCD_W-1:0]     r_tccd;
    logic [FAW_W-1:0]     r_tfaw [4];
    logic [RFC_W-1:0]     r_wait_cnt;

    logic [NUM_BANKS-1:0] r_grant;
    logic                 r_issue_valid;
    logic [2:0]           r_issue_cmd;
    logic [BA_BITS-1:0]   r_issue_bank;
    logic                 r_ref_pending;
    logic                 r_ref_ack;

    logic [NUM_BANKS-1:0] w_tp_zero, w_tras_zero, w_rcd_ok;
    logic [NUM_BANKS-1:0] w_req_act, w_req_col, w_req_pre;
    logic [NUM_BANKS-1:0] w_avail, w_el_col, w_el_oth, w_el_class;
    logic                 w_act_ok, w_col_ok, w_pre_ok;
    logic                 w_faw_free;
    logic [1:0]           w_faw_slot;
    logic                 w_sel_valid;
    logic [BA_BITS-1:0]   w_sel_bank;
    logic [1:0]           w_sel_cmd;
    logic                 w_sel_act, w_sel_col;
    logic                 w_drain_done;

    logic [NUM_BANKS-1:0] w_grant_nxt;
    logic                 w_valid_nxt;
    logic [2:0]           w_cmd_nxt;
    logic [BA_BITS-1:0]   w_bank_nxt;
    logic                 w_ack_nxt;
    logic                 w_pend_nxt;

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        assign w_tp_zero[gb]   = (sif.tP_ba_counter[gb*5 +: 5] == 5'd0);
        assign w_tras_zero[gb] = (sif.tRAS_counter[gb*6 +: 6] == 6'd0);
        // recode 3 means the bank was just activated, so tP is tRCD here
        assign w_rcd_ok[gb]    = (sif.recode[gb*3 +: 3] != 3'd3) || w_tp_zero[gb];
        assign w_req_act[gb]   = (sif.req_cmd[gb*2 +: 2] == RC_ACT);
        assign w_req_col[gb]   = (sif.req_cmd[gb*2 +: 2] == RC_RD) ||
                                 (sif.req_cmd[gb*2 +: 2] == RC_WR);
        assign w_req_pre[gb]   = (sif.req_cmd[gb*2 +: 2] == RC_PRE);
    end

    // Find the lowest-indexed expired tFAW slot
    always_comb begin
        w_faw_free = 1'b0;
        w_faw_slot = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (r_tfaw[k] == '0) begin
                w_faw_free = 1'b1;
                w_faw_slot = 2'(k);
            end
        end
    end

    // A bank granted last cycle is masked while its tP counter reloads
    assign w_avail    = sif.req_valid & ~r_grant;
    assign w_act_ok   = (r_state == ST_NORMAL) && (r_trrd == '0) && w_faw_free;
    assign w_col_ok   = (r_state == ST_NORMAL) && (r_tccd == '0);
    assign w_pre_ok   = (r_state == ST_NORMAL) || (r_state == ST_REF_DRAIN);
    assign w_el_col   = w_avail & w_req_col & w_rcd_ok & {NUM_BANKS{w_col_ok}};
    assign w_el_oth   = w_avail & ((w_req_act & w_tp_zero & {NUM_BANKS{w_act_ok}}) |
                                   (w_req_pre & w_tp_zero & w_tras_zero & {NUM_BANKS{w_pre_ok}}));
    assign w_el_class = (|w_el_col) ? w_el_col : w_el_oth;

    // Round-robin pick: first eligible bank at or after the pointer
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_bank  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!w_sel_valid && w_el_class[r_rr + BA_BITS'(i)]) begin
                w_sel_valid = 1'b1;
                w_sel_bank  = r_rr + BA_BITS'(i);
            end
        end
    end

    assign w_sel_cmd    = sif.req_cmd[{w_sel_bank, 1'b0} +: 2];
    assign w_sel_act    = w_sel_valid && (w_sel_cmd == RC_ACT);
    assign w_sel_col    = w_sel_valid && ((w_sel_cmd == RC_RD) || (w_sel_cmd == RC_WR));
    assign w_drain_done = (sif.bank_open == '0) && (&w_tp_zero) && (r_grant == '0) && !w_sel_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_NORMAL;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL:    if (sif.ref_req)        w_state_nxt = ST_REF_DRAIN;
            ST_REF_DRAIN: if (w_drain_done)       w_state_nxt = ST_REF_ISSUE;
            ST_REF_ISSUE:                         w_state_nxt = ST_REF_WAIT;
            ST_REF_WAIT:  if (r_wait_cnt == '0)   w_state_nxt = ST_NORMAL;
            default:                              w_state_nxt = ST_NORMAL;
        endcase
    end

    // Output values for the next cycle
    always_comb begin
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        w_cmd_nxt   = 3'd0;
        w_bank_nxt  = r_issue_bank;
        w_ack_nxt   = 1'b0;
        w_pend_nxt  = (w_state_nxt == ST_REF_DRAIN);
        if (w_state_nxt == ST_REF_ISSUE) begin
            w_valid_nxt = 1'b1;
            w_cmd_nxt   = 3'd5;
            w_ack_nxt   = 1'b1;
        end else if (w_sel_valid) begin
            w_grant_nxt[w_sel_bank] = 1'b1;
            w_valid_nxt = 1'b1;
            w_cmd_nxt   = {1'b0, w_sel_cmd} + 3'd1;
            w_bank_nxt  = w_sel_bank;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_issue_valid <= 1'b0;
            r_issue_cmd   <= 3'd0;
            r_issue_bank  <= '0;
            r_ref_pending <= 1'b0;
            r_ref_ack     <= 1'b0;
        end else begin
            r_grant       <= w_grant_nxt;
            r_issue_valid <= w_valid_nxt;
            r_issue_cmd   <= w_cmd_nxt;
            r_issue_bank  <= w_bank_nxt;
            r_ref_pending <= w_pend_nxt;
            r_ref_ack     <= w_ack_nxt;
        end
    end

    // Round-robin pointer moves past the bank just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_rr <= '0;
        else if (w_sel_valid) r_rr <= w_sel_bank + 1'b1;
    end

    // Inter-command timers: reload on the relevant command, else count down to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trrd     <= '0;
            r_tccd     <= '0;
            r_wait_cnt <= '0;
            for (int k = 0; k < 4; k++) r_tfaw[k] <= '0;
        end else begin
            if (w_sel_act)           r_trrd <= RRD_W'(TRRD - 1);
            else if (r_trrd != '0)   r_trrd <= r_trrd - 1'b1;

            if (w_sel_col)           r_tccd <= CCD_W'(TCCD - 1);
            else if (r_tccd != '0)   r_tccd <= r_tccd - 1'b1;

            for (int k = 0; k < 4; k++) begin
                if (w_sel_act && (w_faw_slot == 2'(k))) r_tfaw[k] <= FAW_W'(TFAW - 1);
                else if (r_tfaw[k] != '0)              r_tfaw[k] <= r_tfaw[k] - 1'b1;
            end

            if (r_state == ST_REF_ISSUE)  r_wait_cnt <= RFC_W'(TRFC - 1);
            else if (r_wait_cnt != '0)    r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    assign sif.grant       = r_grant;
    assign sif.issue_valid = r_issue_valid;
    assign sif.issue_cmd   = r_issue_cmd;
    assign sif.issue_bank  = r_issue_bank;
    assign sif.ref_pending = r_ref_pending;
    assign sif.ref_ack     = r_ref_ack;
endmodule

// File: doc/bank_cmd_scheduler.md
Name: bank_cmd_scheduler

Overview:
- Per-cycle DRAM command scheduler that sits between the per-bank request queues and the command/address encoder.
- Each bank's eligibility comes from its tP_counter instance (tP_ba_counter, tRAS_counter, recode), plus locally tracked tRRD, tFAW and tCCD.
- Grants at most one command per cycle: row hits (RD/WR) are served first, then ACT/PRE, round-robin within each class.
- Also sequences refresh by draining open banks and issuing REF.

Parameters:
- NUM_BANKS, 8, number of banks; BA_BITS = 3.
- TRRD, 4, ACT-to-ACT (different bank) cycles.
- TFAW, 20, four-activate window, in cycles.
- TCCD, 4, column-to-column command cycles.
- TRFC, 44, REF-to-any-command cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_BANKS  bank b has a pending command.
- req_cmd  in  2*NUM_BANKS  per bank: 00 ACT, 01 RD, 10 WR, 11 PRE.
- bank_open  in  NUM_BANKS  bank b has an open row.
- tP_ba_counter  in  5*NUM_BANKS  per-bank tP counters.
- tRAS_counter  in  6*NUM_BANKS  per-bank tRAS counters.
- recode  in  3*NUM_BANKS  per-bank last-command code (1..6).
- ref_req  in  1  level refresh request.
- grant  out  NUM_BANKS  one-hot pop pulse to bank queue.
- issue_valid  out  1  command valid this cycle.
- issue_cmd  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF.
- issue_bank  out  BA_BITS  target bank.
- ref_pending  out  1  drain in progress; bank FSMs queue PRE for open banks.
- ref_ack  out  1  one-cycle pulse when REF is issued.

Behaviour:
- Reset (async, rst_n low): all outputs 0, rr pointer 0, tRRD/tCCD/four tFAW counters 0, state NORMAL, block mask 0.
- Outputs are registered. Eligibility is sampled in cycle N; grant, issue_* and ref_ack are valid in cycle N+1 for exactly one cycle.
- Per-bank eligibility, with bank not in block mask and req_valid[b]=1:
  - ACT: tP==0 AND tRRD_cnt==0 AND at least one tFAW counter ==0 AND state==NORMAL.
  - RD/WR: (recode!=3 OR tP==0) AND tCCD_cnt==0 AND state==NORMAL.
  - PRE: tP==0 AND tRAS==0. Allowed in NORMAL and REF_DRAIN.
- Block mask: a bank granted in cycle N is ineligible in cycle N+1. This covers the one-cycle lag before its tP_counter reloads.
- Arbitration:
  - If any RD/WR is eligible, pick the first eligible bank at or after rr in that class.
  - Else pick among ACT/PRE the same way.
  - After any grant, rr <= granted bank + 1 (mod NUM_BANKS).
- Local counters:
  - On ACT: tRRD_cnt <= TRRD-1, and the lowest-indexed zero tFAW counter <= TFAW-1.
  - On RD/WR: tCCD_cnt <= TCCD-1.
  - All counters decrement, saturating at 0.
- FSM:
  - NORMAL: ref_req=1 -> REF_DRAIN; ref_pending=1 from the next cycle. A command selected in the same cycle ref_req rises is still issued.
  - REF_DRAIN: only PRE is granted. When bank_open==0, every tP==0 and no grant is in flight -> REF_ISSUE.
  - REF_ISSUE: one cycle with issue_cmd=5, issue_valid=1, ref_ack=1, grant=0; ref_pending drops. Next state REF_WAIT with wait_cnt=TRFC-1.
  - REF_WAIT: no issues. At wait_cnt==0 -> NORMAL.
- When nothing is eligible: issue_valid=0, issue_cmd=0, grant=0, and issue_bank holds its last value.
- Reset mid-refresh returns to NORMAL with all counters cleared. ref_req still high then re-enters REF_DRAIN.

Test Plan:
- Reset mid-traffic: rst_n low with req_valid=8'hFF -> immediately grant=0, issue_valid=0, issue_cmd=0. First grant after release goes to bank 0 if eligible.
- Row-hit priority: bank2 RD with recode=1, tP=0, and bank0 ACT eligible in the same cycle -> next cycle issue_cmd=2, issue_bank=2. Following cycle issues ACT bank0.
- tRCD gating: bank3 RD, recode=3, tP=2 -> no issue until tP==0, then RD bank3 one cycle later. Block mask prevents a second grant to bank3 in the next cycle.
- tRRD/tFAW: ACT requests held on banks 0-7 with tP=0 -> ACT spacing is exactly TRRD=4 cycles. The 5th ACT issues no earlier than TFAW=20 cycles after the 1st.
- PRE vs tRAS: bank1 PRE, tP=0, tRAS=5 -> PRE issued only after tRAS reaches 0.
- Refresh: ref_req=1 with bank_open=8'h05 -> ACT/RD/WR suppressed, PREs granted to banks 0 and 2. Once bank_open=0 and all tP=0: REF with ref_ack pulse, then no issue for 44 cycles, then NORMAL.
